// File: rtl/tri_tile_dispatch_pkg.sv
// Shared rasterizer types and constants for the triangle tile dispatcher.
//   - fixed-point format (signed 12.4), tile geometry, tile grid size
//   - coord_2d_t / coord_3d_t vertex types, polygon_t beat metadata
//   - dispatcher FSM state type and small min/max/clamp helpers
package tri_tile_dispatch_pkg;

   localparam int unsigned FX_INT_BITS  = 12;
   localparam int unsigned FX_FRAC_BITS = 4;
   localparam int unsigned FX_W         = FX_INT_BITS + FX_FRAC_BITS;
   localparam int unsigned TILE_WIDTH   = 16;
   // Pixel-to-tile shift in fixed point: fraction bits plus log2 of the tile width.
   localparam int unsigned TILE_SHIFT   = FX_FRAC_BITS + $clog2(TILE_WIDTH);
   localparam int unsigned TILE_COLUMNS = 640 / TILE_WIDTH;
   localparam int unsigned TILE_ROWS    = 480 / TILE_WIDTH;
   localparam int unsigned TILE_IDX_W   = 6;

   typedef logic signed [FX_W-1:0] fx_t;
   typedef logic [TILE_IDX_W-1:0]  tile_idx_t;

   typedef struct packed {
      fx_t x;
      fx_t y;
   } coord_2d_t;

   typedef struct packed {
      fx_t x;
      fx_t y;
      fx_t z;
   } coord_3d_t;

   // tile_y is 5 bits so that row 29 is reachable.
   typedef struct packed {
      logic [3:0] color;
      logic [1:0] padding;
      logic [4:0] tile_y;
      logic [4:0] tile_x;
   } polygon_t;

   typedef enum logic [1:0] {
      StIdle,
      StSetup,
      StEmit
   } disp_state_e;

   function automatic fx_t fx_min3(fx_t a, fx_t b, fx_t c);
      fx_t m;
      m = (a < b) ? a : b;
      return (c < m) ? c : m;
   endfunction

   function automatic fx_t fx_max3(fx_t a, fx_t b, fx_t c);
      fx_t m;
      m = (a > b) ? a : b;
      return (c > m) ? c : m;
   endfunction

   // Fixed-point coordinate -> tile index, clamped to [0, last].
   function automatic tile_idx_t tile_clamp(fx_t c, int unsigned last);
      fx_t t;
      t = c >>> TILE_SHIFT;
      if (t < 0) begin
         return '0;
      end else if (int'(t) > int'(last)) begin
         return tile_idx_t'(last);
      end else begin
         return tile_idx_t'(t);
      end
   endfunction

   function automatic polygon_t make_meta(logic [3:0] color, tile_idx_t ty, tile_idx_t tx);
      polygon_t m;
      m.color   = color;
      m.padding = 2'b00;
      m.tile_y  = ty[4:0];
      m.tile_x  = tx[4:0];
      return m;
   endfunction

endpackage

// File: rtl/tri_tile_dispatch_if.sv
// Triangle beat channel: valid/ready handshake carrying three vertices and metadata.
//   master: drives vld, v0..v2, meta; samples rdy
//   slave : samples vld, v0..v2, meta; drives rdy
// On the dispatcher input only meta.color is meaningful.
interface tri_tile_dispatch_if;
   import tri_tile_dispatch_pkg::*;

   logic      vld;
   logic      rdy;
   coord_3d_t v0;
   coord_3d_t v1;
   coord_3d_t v2;
   polygon_t  meta;

   modport master (output vld, output v0, output v1, output v2, output meta, input rdy);
   modport slave  (input vld, input v0, input v1, input v2, input meta, output rdy);

endinterface

// File: rtl/tri_tile_dispatch_bbox.sv
// Combinational triangle bounding-box and cull evaluation.
//   p0..p2     : screen-space vertices (signed 12.4)
//   tx_lo/hi   : clamped tile column range
//   ty_lo/hi   : clamped tile row range
//   offscreen  : box lies entirely left/above/right/below the screen
//   degenerate : signed doubled area is zero
module tri_bbox
   import tri_tile_dispatch_pkg::*;
#(
   parameter int unsigned SCREEN_W = 640,
   parameter int unsigned SCREEN_H = 480
) (
   input  coord_2d_t p0,
   input  coord_2d_t p1,
   input  coord_2d_t p2,
   output tile_idx_t tx_lo,
   output tile_idx_t tx_hi,
   output tile_idx_t ty_lo,
   output tile_idx_t ty_hi,
   output logic      offscreen,
   output logic      degenerate
);

   localparam fx_t XLimit = fx_t'(SCREEN_W * (2 ** FX_FRAC_BITS));
   localparam fx_t YLimit = fx_t'(SCREEN_H * (2 ** FX_FRAC_BITS));

   fx_t x_min, x_max, y_min, y_max;

   assign x_min = fx_min3(p0.x, p1.x, p2.x);
   assign x_max = fx_max3(p0.x, p1.x, p2.x);
   assign y_min = fx_min3(p0.y, p1.y, p2.y);
   assign y_max = fx_max3(p0.y, p1.y, p2.y);

   assign offscreen = (x_max < 0) || (y_max < 0) || (x_min >= XLimit) || (y_min >= YLimit);

   assign tx_lo = tile_clamp(x_min, SCREEN_W / TILE_WIDTH - 1);
   assign tx_hi = tile_clamp(x_max, SCREEN_W / TILE_WIDTH - 1);
   assign ty_lo = tile_clamp(y_min, SCREEN_H / TILE_WIDTH - 1);
   assign ty_hi = tile_clamp(y_max, SCREEN_H / TILE_WIDTH - 1);

   // Edge vectors need 17 bits; their cross product fits in 34 bits signed.
   logic signed [FX_W:0]     e1x, e1y, e2x, e2y;
   logic signed [2*FX_W+1:0] area;

   assign e1x = {p1.x[FX_W-1], p1.x} - {p0.x[FX_W-1], p0.x};
   assign e1y = {p1.y[FX_W-1], p1.y} - {p0.y[FX_W-1], p0.y};
   assign e2x = {p2.x[FX_W-1], p2.x} - {p0.x[FX_W-1], p0.x};
   assign e2y = {p2.y[FX_W-1], p2.y} - {p0.y[FX_W-1], p0.y};

   assign area       = (e1x * e2y) - (e2x * e1y);
   assign degenerate = (area == '0);

endmodule

// File: rtl/tri_tile_dispatch.sv
// Transmit side of the rasterizer triangle interface.
// Accepts one triangle, computes its clamped tile bounding box, culls it when off-screen or
// (optionally) degenerate, otherwise emits one beat per covered 16x16 tile in raster order.
//   clk, rst_n : clock, synchronous active-low reset
//   in_if      : slave; accepted vertices and meta.color
//   out_if     : master; registered vertices plus {color, 0, tile_y, tile_x} per beat
//   busy       : FSM not idle
//   drop_cnt   : culled-triangle count, saturating
module tri_tile_dispatch
   import tri_tile_dispatch_pkg::*;
#(
   parameter int unsigned SCREEN_W        = 640,
   parameter int unsigned SCREEN_H        = 480,
   parameter bit          CULL_DEGENERATE = 1'b1
) (
   input  logic                clk,
   input  logic                rst_n,
   tri_tile_dispatch_if.slave  in_if,
   tri_tile_dispatch_if.master out_if,
   output logic                busy,
   output logic [15:0]         drop_cnt
);

   disp_state_e state_q;
   coord_3d_t   v0_q, v1_q, v2_q;
   polygon_t    meta_q;
   logic        out_vld_q;
   logic [15:0] drop_cnt_q;
   logic [3:0]  color_q;
   tile_idx_t   tx_q, ty_q, tx_lo_q, tx_hi_q, ty_hi_q;

   logic        in_rdy;
   tile_idx_t   bb_tx_lo, bb_tx_hi, bb_ty_lo, bb_ty_hi;
   logic        bb_offscreen, bb_degenerate;
   logic        cull;
   logic        last_tile;
   tile_idx_t   tx_inc, ty_inc;

   // Only the color field of the input metadata is used.
   logic unused_in_meta;
   assign unused_in_meta = ^{in_if.meta.padding, in_if.meta.tile_y, in_if.meta.tile_x};

   tri_bbox #(
      .SCREEN_W (SCREEN_W),
      .SCREEN_H (SCREEN_H)
   ) u_bbox (
      .p0         ('{x: v0_q.x, y: v0_q.y}),
      .p1         ('{x: v1_q.x, y: v1_q.y}),
      .p2         ('{x: v2_q.x, y: v2_q.y}),
      .tx_lo      (bb_tx_lo),
      .tx_hi      (bb_tx_hi),
      .ty_lo      (bb_ty_lo),
      .ty_hi      (bb_ty_hi),
      .offscreen  (bb_offscreen),
      .degenerate (bb_degenerate)
   );

   assign in_rdy    = rst_n && (state_q == StIdle);
   assign cull      = bb_offscreen || (CULL_DEGENERATE && bb_degenerate);
   assign last_tile = (tx_q == tx_hi_q) && (ty_q == ty_hi_q);
   assign tx_inc    = tx_q + TILE_IDX_W'(1);
   assign ty_inc    = ty_q + TILE_IDX_W'(1);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= StIdle;
         out_vld_q  <= 1'b0;
         v0_q       <= '0;
         v1_q       <= '0;
         v2_q       <= '0;
         meta_q     <= '0;
         drop_cnt_q <= '0;
         color_q    <= '0;
         tx_q       <= '0;
         ty_q       <= '0;
         tx_lo_q    <= '0;
         tx_hi_q    <= '0;
         ty_hi_q    <= '0;
      end else begin
         case (state_q)
            StIdle: begin
               if (in_if.vld && in_rdy) begin
                  v0_q    <= in_if.v0;
                  v1_q    <= in_if.v1;
                  v2_q    <= in_if.v2;
                  color_q <= in_if.meta.color;
                  state_q <= StSetup;
               end
            end
            StSetup: begin
               if (cull) begin
                  if (drop_cnt_q != 16'hFFFF) begin
                     drop_cnt_q <= drop_cnt_q + 16'd1;
                  end
                  state_q <= StIdle;
               end else begin
                  tx_q      <= bb_tx_lo;
                  ty_q      <= bb_ty_lo;
                  tx_lo_q   <= bb_tx_lo;
                  tx_hi_q   <= bb_tx_hi;
                  ty_hi_q   <= bb_ty_hi;
                  out_vld_q <= 1'b1;
                  meta_q    <= make_meta(color_q, bb_ty_lo, bb_tx_lo);
                  state_q   <= StEmit;
               end
            end
            StEmit: begin
               // Everything holds while the raster stalls.
               if (out_if.rdy) begin
                  if (last_tile) begin
                     out_vld_q <= 1'b0;
                     state_q   <= StIdle;
                  end else if (tx_q < tx_hi_q) begin
                     tx_q   <= tx_inc;
                     meta_q <= make_meta(color_q, ty_q, tx_inc);
                  end else begin
                     tx_q   <= tx_lo_q;
                     ty_q   <= ty_inc;
                     meta_q <= make_meta(color_q, ty_inc, tx_lo_q);
                  end
               end
            end
            default: begin
               state_q   <= StIdle;
               out_vld_q <= 1'b0;
            end
         endcase
      end
   end

   assign in_if.rdy   = in_rdy;
   assign out_if.vld  = out_vld_q;
   assign out_if.v0   = v0_q;
   assign out_if.v1   = v1_q;
   assign out_if.v2   = v2_q;
   assign out_if.meta = meta_q;
   assign busy        = (state_q != StIdle);
   assign drop_cnt    = drop_cnt_q;

endmodule

// File: tb/tb_tri_tile_dispatch.sv
// Self-checking bench for tri_tile_dispatch. Two instances share stimulus: one culls
// degenerate triangles, one does not. A table of triangles with hand-computed tile ranges
// drives both; extra sequences cover beat timing and reset in mid-dispatch.
module tb_tri_tile_dispatch;
   import tri_tile_dispatch_pkg::*;

   logic        clk;
   logic        rst_n;
   logic        busy, busy_nd;
   logic [15:0] drop_cnt, drop_nd;

   tri_tile_dispatch_if in_if ();
   tri_tile_dispatch_if out_if ();
   tri_tile_dispatch_if nd_in ();
   tri_tile_dispatch_if nd_out ();

   assign nd_in.vld  = in_if.vld;
   assign nd_in.v0   = in_if.v0;
   assign nd_in.v1   = in_if.v1;
   assign nd_in.v2   = in_if.v2;
   assign nd_in.meta = in_if.meta;
   assign nd_out.rdy = out_if.rdy;

   tri_tile_dispatch #(
      .SCREEN_W        (640),
      .SCREEN_H        (480),
      .CULL_DEGENERATE (1'b1)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_if    (in_if),
      .out_if   (out_if),
      .busy     (busy),
      .drop_cnt (drop_cnt)
   );

   tri_tile_dispatch #(
      .SCREEN_W        (640),
      .SCREEN_H        (480),
      .CULL_DEGENERATE (1'b0)
   ) dut_nd (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_if    (nd_in),
      .out_if   (nd_out),
      .busy     (busy_nd),
      .drop_cnt (drop_nd)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_err    = 0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   typedef struct {
      string name;
      int    x0, y0, x1, y1, x2, y2;
      int    color;
      bit    rnd;
      bit    cull;
      bit    cull_nd;
      int    tx_lo, tx_hi, ty_lo, ty_hi;
   } vec_t;

   vec_t vecs[9];

   // out_rdy policy: always ready, or pseudo-random.
   bit rnd_mode = 1'b0;
   initial begin
      out_if.rdy = 1'b1;
      forever begin
         @(negedge clk);
         out_if.rdy = rnd_mode ? ($urandom_range(0, 1) == 1) : 1'b1;
      end
   end

   // Beat monitor and stall-stability checks, sampled mid-low-phase.
   logic [15:0] q_meta[$];
   int          q_cyc[$];
   logic [15:0] nd_meta[$];
   bit          stall_prev = 1'b0;
   logic [15:0] snap_meta;
   coord_3d_t   snap_v0;
   initial begin
      forever begin
         @(negedge clk);
         #2;
         if (rst_n) begin
            if (stall_prev) begin
               check("stall_vld", out_if.vld, 1'b1);
               check("stall_meta", out_if.meta, snap_meta);
               check("stall_v0", out_if.v0, snap_v0);
            end
            if (out_if.vld && out_if.rdy) begin
               q_meta.push_back(out_if.meta);
               q_cyc.push_back(cyc);
            end
            if (nd_out.vld && nd_out.rdy) nd_meta.push_back(nd_out.meta);
            stall_prev = out_if.vld && !out_if.rdy;
            snap_meta  = out_if.meta;
            snap_v0    = out_if.v0;
         end else begin
            stall_prev = 1'b0;
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic coord_3d_t mk_vtx(int x, int y, int z);
      coord_3d_t v;
      v.x = fx_t'(x);
      v.y = fx_t'(y);
      v.z = fx_t'(z);
      return v;
   endfunction

   // Returns the first cycle the culling instance shows in_rdy, once both are idle.
   task automatic wait_idle(output int rdy_cyc, output bit ok);
      rdy_cyc = -1;
      ok      = 1'b0;
      for (int k = 0; k < 3000; k++) begin
         @(negedge clk);
         #2;
         if (rdy_cyc < 0 && in_if.rdy) rdy_cyc = cyc;
         if (!busy && !busy_nd) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic send(input vec_t r, input int zseed, output int t0);
      @(negedge clk);
      in_if.v0   = mk_vtx(r.x0, r.y0, 16'h1230 + zseed);
      in_if.v1   = mk_vtx(r.x1, r.y1, 16'h4560 + zseed);
      in_if.v2   = mk_vtx(r.x2, r.y2, 16'h7890 + zseed);
      in_if.meta = {4'(r.color), 12'h000};
      in_if.vld  = 1'b1;
      t0         = cyc;
      @(posedge clk);
      #1;
      in_if.vld = 1'b0;
   endtask

   task automatic run_vec(input int i);
      vec_t        r;
      int          t0, rdy_cyc, n_exp, n_exp_nd, last;
      bit          ok;
      logic [15:0] d0, d0n;
      logic [15:0] exp_q[$];
      r = vecs[i];
      // The tile_x field is 5 bits wide, so columns above 31 appear modulo 32.
      for (int ty = r.ty_lo; ty <= r.ty_hi; ty++) begin
         for (int tx = r.tx_lo; tx <= r.tx_hi; tx++) begin
            exp_q.push_back({4'(r.color), 2'b00, 5'(ty), 5'(tx)});
         end
      end
      rnd_mode = r.rnd;
      q_meta.delete();
      q_cyc.delete();
      nd_meta.delete();
      d0  = drop_cnt;
      d0n = drop_nd;
      send(r, i, t0);
      wait_idle(rdy_cyc, ok);
      check({r.name, "_idle_timeout"}, ok, 1'b1);
      rnd_mode = 1'b0;

      n_exp    = r.cull ? 0 : exp_q.size();
      n_exp_nd = r.cull_nd ? 0 : exp_q.size();
      check({r.name, "_beats"}, q_meta.size(), n_exp);
      for (int k = 0; k < q_meta.size() && k < n_exp; k++) begin
         check($sformatf("%s_meta%0d", r.name, k), q_meta[k], exp_q[k]);
      end
      check({r.name, "_beats_nd"}, nd_meta.size(), n_exp_nd);
      for (int k = 0; k < nd_meta.size() && k < n_exp_nd; k++) begin
         check($sformatf("%s_nd_meta%0d", r.name, k), nd_meta[k], exp_q[k]);
      end
      check({r.name, "_drop"}, drop_cnt, d0 + 16'(r.cull));
      check({r.name, "_drop_nd"}, drop_nd, d0n + 16'(r.cull_nd));
      check({r.name, "_v0"}, out_if.v0, mk_vtx(r.x0, r.y0, 16'h1230 + i));
      check({r.name, "_v2"}, out_if.v2, mk_vtx(r.x2, r.y2, 16'h7890 + i));

      if (!r.rnd) begin
         if (r.cull) begin
            check({r.name, "_rdy_again"}, rdy_cyc, t0 + 2);
         end else if (q_cyc.size() > 0) begin
            last = q_cyc[q_cyc.size()-1];
            check({r.name, "_first_cyc"}, q_cyc[0], t0 + 2);
            check({r.name, "_last_cyc"}, last, t0 + 1 + n_exp);
            check({r.name, "_rdy_again"}, rdy_cyc, last + 1);
         end
      end
   endtask

   task automatic set_vec(input int i, input string name, input int x0, input int y0,
                          input int x1, input int y1, input int x2, input int y2,
                          input int color, input bit rnd, input bit cull, input bit cull_nd,
                          input int tx_lo, input int tx_hi, input int ty_lo, input int ty_hi);
      vecs[i] = '{name, x0, y0, x1, y1, x2, y2, color, rnd, cull, cull_nd,
                  tx_lo, tx_hi, ty_lo, ty_hi};
   endtask

   int  t_rst;
   int  rc;
   bit  ok_w;

   initial begin
      //      idx name          x0       y0       x1      y1       x2      y2   col rnd c  cnd  tx     ty
      set_vec(0, "t1_rdy1",     'h0100,  'h0100,  'h0400, 'h0100,  'h0100, 'h0300, 5, 0, 0, 0, 1, 4, 1, 3);
      set_vec(1, "t1_rdyrand",  'h0100,  'h0100,  'h0400, 'h0100,  'h0100, 'h0300, 5, 1, 0, 0, 1, 4, 1, 3);
      set_vec(2, "left_off",    -'h0200, 'h0100, -'h0100, 'h0300, -'h0300, 'h0200, 3, 0, 1, 1, 0, 0, 0, 0);
      set_vec(3, "x_span",      -'h0200, 'h0000,  'h3000, 'h0000,  'h0100, 'h0050, 9, 0, 0, 0, 0, 39, 0, 0);
      set_vec(4, "collinear",   'h0000,  'h0000,  'h0100, 'h0100,  'h0200, 'h0200, 7, 0, 1, 0, 0, 2, 0, 2);
      set_vec(5, "right_off",   'h2800,  'h0000,  'h2900, 'h0100,  'h2A00, 'h0050, 2, 0, 1, 1, 0, 0, 0, 0);
      set_vec(6, "corner",      'h27F0,  'h1DF0,  'h2900, 'h1DF0,  'h27F0, 'h2000, 15, 0, 0, 0, 39, 39, 29, 29);
      set_vec(7, "one_tile",    'h0510,  'h0520,  'h0580, 'h0530,  'h0540, 'h05F0, 1, 0, 0, 0, 5, 5, 5, 5);
      set_vec(8, "top_off",     'h0000, -'h0010,  'h0100, -'h0100, 'h0050, -'h0020, 4, 0, 1, 1, 0, 0, 0, 0);

      rst_n      = 1'b0;
      in_if.vld  = 1'b0;
      in_if.v0   = '0;
      in_if.v1   = '0;
      in_if.v2   = '0;
      in_if.meta = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      #2;
      check("rst_in_rdy_low", in_if.rdy, 1'b0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      #2;
      check("rst_out_vld", out_if.vld, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_drop_cnt", drop_cnt, 16'h0000);
      check("rst_out_meta", out_if.meta, 16'h0000);
      check("rst_out_v0", out_if.v0, 48'h0);
      check("rst_in_rdy", in_if.rdy, 1'b1);

      for (int i = 0; i < 9; i++) run_vec(i);

      // Reset during the 5th beat of the 12-tile triangle.
      rnd_mode = 1'b0;
      q_meta.delete();
      q_cyc.delete();
      nd_meta.delete();
      send(vecs[0], 0, t_rst);
      for (int k = 0; k < 100 && q_meta.size() < 4; k++) begin
         @(negedge clk);
         #2;
      end
      @(posedge clk);
      #1;
      check("rst_mid_vld_before", out_if.vld, 1'b1);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      #1;
      check("rst_mid_out_vld", out_if.vld, 1'b0);
      check("rst_mid_busy", busy, 1'b0);
      check("rst_mid_busy_nd", busy_nd, 1'b0);
      check("rst_mid_beats", q_meta.size(), 4);
      check("rst_mid_drop", drop_cnt, 16'h0000);
      wait_idle(rc, ok_w);
      check("rst_mid_idle", ok_w, 1'b1);

      // A fresh triangle after the abort starts from its first tile.
      run_vec(0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
